// File: rtl/main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_ctrl
// Purpose  : Fixed-latency main-memory model serving L2 line fills/write-backs.
// Revision : 1.0
// ============================================================================
module main_memory_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 4,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_stb,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stb,
    output logic              busy
);

    localparam int BYTE_OFS = 3;
    localparam int WORD_AW  = $clog2(MEM_WORDS);
    localparam int BEAT_W   = $clog2(LINE_BEATS);
    localparam int LINE_W   = WORD_AW - BEAT_W;

    localparam logic [7:0]        LAT_LAST  = 8'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [7:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;
    logic [BEAT_W-1:0]   beat_nxt;

    logic [DATA_W-1:0]   mem [MEM_WORDS];

    assign beat_nxt = beat_q + BEAT_W'(1);

    // Byte offset and beat bits never select a line; high bits alias by truncation.
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[BYTE_OFS+BEAT_W-1:0];

    generate
        if (ADDR_W > BYTE_OFS + WORD_AW) begin : g_addr_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:BYTE_OFS+WORD_AW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            line_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        line_d  = line_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_stb) begin
                    state_d = ST_WAIT;
                    we_d    = we;
                    line_d  = addr[BYTE_OFS+WORD_AW-1:BYTE_OFS+BEAT_W];
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            ST_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                    if (!we_q) begin
                        rdata_d = mem[{line_q, {BEAT_W{1'b0}}}];
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_BURST: begin
                mem_we = we_q;
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_nxt;
                    // Prefetch the next beat so rdata changes in step with stb.
                    if (!we_q) begin
                        rdata_d = mem[{line_q, beat_nxt}];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage is never reset; an aborted burst keeps the words already written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{line_q, beat_q}] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign stb   = (state_q == ST_BURST);
    assign busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory_ctrl
// Purpose  : Directed self-checking bench for main_memory_ctrl.
// Revision : 1.0
// ============================================================================
module tb_main_memory_ctrl;

    localparam int L  = 8;
    localparam int LB = 4;
    localparam logic [63:0] EXP_STB = 64'hF << L;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_stb;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        stb;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] obs_stb;
    logic [63:0] obs_busy;
    logic [63:0] obs_data [8];
    int          obs_n;
    logic [63:0] wbeats [4];
    logic [63:0] abeats [4];

    always #5 clk = ~clk;

    main_memory_ctrl #(
        .ADDR_W(32), .DATA_W(64), .LINE_BEATS(LB), .MEM_WORDS(1024), .LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr_stb(addr_stb), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .stb(stb), .busy(busy)
    );

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_wait busy=%b required 0", busy);
            errors++;
        end
    endtask

    // Issues one request at a negedge and records stb/busy/rdata per cycle (n = cycles after accept).
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input bit hold,
                           input bit noise, input int abort_n, input int ncyc);
        obs_stb  = '0;
        obs_busy = '0;
        obs_n    = 0;
        addr_stb = 1'b1;
        we       = t_we;
        addr     = t_addr;
        wdata    = wbeats[0];
        @(posedge clk);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            obs_stb[n]  = stb;
            obs_busy[n] = busy;
            if (t_we && obs_n < 4) wdata = wbeats[obs_n];
            if (stb === 1'b1) begin
                if (obs_n < 8) obs_data[obs_n] = rdata;
                obs_n++;
            end
            if (!hold || n == L + LB + 1) addr_stb = 1'b0;
            if (noise && (n == 3 || n == L + 1)) begin
                addr_stb = 1'b1;
                addr     = 32'h0000_0100;
                we       = ~t_we;
            end
            if (n == abort_n) begin
                #2 rst_n = 1'b0;
                #1;
                addr_stb = 1'b0;
                return;
            end
        end
        addr_stb = 1'b0;
    endtask

    task automatic check_line(input string name, input int first);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_data[first + k] !== wbeats[k]) begin
                $display("FAIL %s beat%0d got %h required %h", name, k, obs_data[first + k], wbeats[k]);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr_stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (stb !== 1'b0) begin $display("FAIL reset_stb got %b required 0", stb); errors++; end
        checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got %b required 0", busy); errors++; end
        checks++;
        if (rdata !== 64'h0) begin $display("FAIL reset_rdata got %h required 0", rdata); errors++; end
        rst_n = 1'b1;
    endtask

    task automatic test_write_fill();
        wbeats[0] = 64'h1111_1111_1111_1111;
        wbeats[1] = 64'h2222_2222_2222_2222;
        wbeats[2] = 64'h3333_3333_3333_3333;
        wbeats[3] = 64'h4444_4444_4444_4444;
        wait_idle();
        run_txn(1'b1, 32'h0000_0040, 1'b0, 1'b0, -1, L + LB + 3);
        checks++;
        if (obs_busy[0] !== 1'b1) begin $display("FAIL wr_busy_start got %b required 1", obs_busy[0]); errors++; end
        checks++;
        if (obs_stb !== EXP_STB) begin $display("FAIL wr_stb_pattern got %h required %h", obs_stb, EXP_STB); errors++; end
        checks++;
        if (obs_busy[L+LB-1] !== 1'b1 || obs_busy[L+LB] !== 1'b0) begin
            $display("FAIL wr_busy_end got %b%b required 10", obs_busy[L+LB-1], obs_busy[L+LB]); errors++;
        end
        wait_idle();
        run_txn(1'b0, 32'h0000_0058, 1'b0, 1'b0, -1, L + LB + 3);
        checks++;
        if (obs_stb !== EXP_STB) begin $display("FAIL rd_stb_pattern got %h required %h", obs_stb, EXP_STB); errors++; end
        check_line("rd_0x58", 0);
        checks++;
        if (rdata !== wbeats[3]) begin $display("FAIL rd_hold_last got %h required %h", rdata, wbeats[3]); errors++; end
    endtask

    task automatic test_alias();
        wait_idle();
        run_txn(1'b0, 32'h0000_2047, 1'b0, 1'b0, -1, L + LB + 3);
        checks++;
        if (obs_n !== 4) begin $display("FAIL alias_beats got %0d required 4", obs_n); errors++; end
        check_line("alias_0x2047", 0);
    endtask

    task automatic test_busy_reject();
        wait_idle();
        run_txn(1'b0, 32'h0000_0040, 1'b0, 1'b1, -1, L + LB + 8);
        checks++;
        if (obs_stb !== EXP_STB) begin $display("FAIL reject_stb got %h required %h", obs_stb, EXP_STB); errors++; end
        check_line("reject_data", 0);
    endtask

    task automatic test_reset_mid_wait();
        wait_idle();
        run_txn(1'b0, 32'h0000_0040, 1'b0, 1'b0, 3, L + LB + 3);
        checks++;
        if (stb !== 1'b0) begin $display("FAIL rstwait_stb got %b required 0", stb); errors++; end
        checks++;
        if (busy !== 1'b0) begin $display("FAIL rstwait_busy got %b required 0", busy); errors++; end
        checks++;
        if (rdata !== 64'h0) begin $display("FAIL rstwait_rdata got %h required 0", rdata); errors++; end
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        run_txn(1'b0, 32'h0000_0040, 1'b0, 1'b0, -1, L + LB + 3);
        checks++;
        if (obs_stb !== EXP_STB) begin $display("FAIL after_rst_stb got %h required %h", obs_stb, EXP_STB); errors++; end
        check_line("after_rst_data", 0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp2;
        exp2 = EXP_STB | (EXP_STB << (L + LB + 1));
        wait_idle();
        run_txn(1'b0, 32'h0000_0040, 1'b1, 1'b0, -1, 2 * (L + LB + 1) + 2);
        checks++;
        if (obs_stb !== exp2) begin $display("FAIL b2b_stb got %h required %h", obs_stb, exp2); errors++; end
        checks++;
        if (obs_busy[L+LB] !== 1'b0 || obs_busy[L+LB+1] !== 1'b1) begin
            $display("FAIL b2b_busy_gap got %b%b required 01", obs_busy[L+LB], obs_busy[L+LB+1]); errors++;
        end
        checks++;
        if (obs_n !== 8) begin $display("FAIL b2b_beats got %0d required 8", obs_n); errors++; end
        check_line("b2b_second", 4);
    endtask

    task automatic test_reset_mid_write();
        abeats[0] = 64'hA0A0_0000_0000_00A0;
        abeats[1] = 64'hA1A1_0000_0000_00A1;
        abeats[2] = 64'hA2A2_0000_0000_00A2;
        abeats[3] = 64'hA3A3_0000_0000_00A3;
        for (int k = 0; k < 4; k++) wbeats[k] = abeats[k];
        wait_idle();
        run_txn(1'b1, 32'h0000_0100, 1'b0, 1'b0, -1, L + LB + 3);
        wbeats[0] = 64'hB0B0_1111_2222_00B0;
        wbeats[1] = 64'hB1B1_1111_2222_00B1;
        wbeats[2] = 64'hB2B2_1111_2222_00B2;
        wbeats[3] = 64'hB3B3_1111_2222_00B3;
        wait_idle();
        run_txn(1'b1, 32'h0000_0100, 1'b0, 1'b0, L + 2, L + LB + 3);
        @(negedge clk);
        rst_n = 1'b1;
        wbeats[2] = abeats[2];
        wbeats[3] = abeats[3];
        wait_idle();
        run_txn(1'b0, 32'h0000_0100, 1'b0, 1'b0, -1, L + LB + 3);
        check_line("partial_write", 0);
    endtask

    initial begin
        test_reset();
        test_write_fill();
        test_alias();
        test_busy_reject();
        test_reset_mid_wait();
        test_back_to_back();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
